// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that time-shares one i2c_master write engine between
// NUM_REQ requesters and returns each owner its ACK/NACK result with a done pulse.
module i2c_master_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 4,
  parameter int XFER_TIMEOUT  = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   ack_ok,
  output logic                   timeout_err,
  output logic                   arb_busy,
  output logic                   m_enable,
  output logic [6:0]             m_slave_addr,
  output logic [7:0]             m_data,
  input  logic                   m_busy,
  input  logic                   m_ack_received
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(XFER_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] XFER_LIM  = CNT_W'(XFER_TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 ack_ok_q, ack_ok_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 arb_busy_q, arb_busy_d;
  logic                 m_enable_q, m_enable_d;
  logic [6:0]           m_slave_addr_q, m_slave_addr_d;
  logic [7:0]           m_data_q, m_data_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;

  logic [6:0]           addr_arr [NUM_REQ];
  logic [7:0]           data_arr [NUM_REQ];
  logic [PTR_W-1:0]     win_idx;
  logic                 win_found;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_arr[gi] = req_addr[7*gi +: 7];
    assign data_arr[gi] = req_data[8*gi +: 8];
  end

  // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_d        = owner_q;
    done_d         = '0;
    ack_ok_d       = 1'b0;
    timeout_err_d  = 1'b0;
    m_enable_d     = 1'b0;
    m_slave_addr_d = m_slave_addr_q;
    m_data_d       = m_data_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;

    unique case (state_q)
      IDLE: begin
        // A master still busy from an abandoned transfer blocks every grant.
        if (win_found && !m_busy) begin
          grant_d        = NUM_REQ'(1) << win_idx;
          owner_d        = win_idx;
          m_slave_addr_d = addr_arr[win_idx];
          m_data_d       = data_arr[win_idx];
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        m_enable_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        if (m_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == START_LIM) begin
            done_d        = grant_q;
            timeout_err_d = 1'b1;
            state_d       = COMPLETE;
          end
        end
      end
      WAIT_DONE: begin
        // ack_received is still valid in the master's first idle cycle.
        if (!m_busy) begin
          done_d   = grant_q;
          ack_ok_d = m_ack_received;
          state_d  = COMPLETE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == XFER_LIM) begin
            done_d        = grant_q;
            timeout_err_d = 1'b1;
            state_d       = COMPLETE;
          end
        end
      end
      COMPLETE: begin
        grant_d  = '0;
        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      owner_q        <= '0;
      done_q         <= '0;
      ack_ok_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
      arb_busy_q     <= 1'b0;
      m_enable_q     <= 1'b0;
      m_slave_addr_q <= '0;
      m_data_q       <= '0;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      owner_q        <= owner_d;
      done_q         <= done_d;
      ack_ok_q       <= ack_ok_d;
      timeout_err_q  <= timeout_err_d;
      arb_busy_q     <= arb_busy_d;
      m_enable_q     <= m_enable_d;
      m_slave_addr_q <= m_slave_addr_d;
      m_data_q       <= m_data_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign ack_ok       = ack_ok_q;
  assign timeout_err  = timeout_err_q;
  assign arb_busy     = arb_busy_q;
  assign m_enable     = m_enable_q;
  assign m_slave_addr = m_slave_addr_q;
  assign m_data       = m_data_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: a small i2c_master model answers
// m_enable, and a scoreboard queue holds the expected outcome of each grant.
module tb_i2c_master_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 4;
  localparam int XFER_TIMEOUT  = 1024;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req;
  logic [7*NUM_REQ-1:0]   req_addr;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     done;
  logic                   ack_ok;
  logic                   timeout_err;
  logic                   arb_busy;
  logic                   m_enable;
  logic [6:0]             m_slave_addr;
  logic [7:0]             m_data;
  logic                   m_busy;
  logic                   m_ack_received;

  typedef struct {
    logic [3:0] g;
    logic [6:0] a;
    logic [7:0] d;
    logic       ack;
    logic       tmo;
    bit         stmo;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  bit   mdl_stuck;
  bit   mdl_no_start;
  bit   mdl_ack;
  int   mdl_len;
  int   mdl_cnt;

  int         cyc;
  logic [3:0] seen;

  always #5 clk = ~clk;

  i2c_master_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .START_TIMEOUT (START_TIMEOUT),
    .XFER_TIMEOUT  (XFER_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .grant          (grant),
    .done           (done),
    .ack_ok         (ack_ok),
    .timeout_err    (timeout_err),
    .arb_busy       (arb_busy),
    .m_enable       (m_enable),
    .m_slave_addr   (m_slave_addr),
    .m_data         (m_data),
    .m_busy         (m_busy),
    .m_ack_received (m_ack_received)
  );

  // i2c_master model: acts just after each falling edge.
  initial begin
    m_busy         = 1'b0;
    m_ack_received = 1'b0;
    mdl_cnt        = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        m_busy  = 1'b0;
        mdl_cnt = 0;
      end else if (m_busy) begin
        if (!mdl_stuck) begin
          if (mdl_cnt <= 1) begin
            m_busy         = 1'b0;
            m_ack_received = mdl_ack;
            mdl_cnt        = 0;
          end else begin
            mdl_cnt = mdl_cnt - 1;
          end
        end
      end else if (m_enable && !mdl_no_start) begin
        m_busy         = 1'b1;
        m_ack_received = 1'b0;
        mdl_cnt        = mdl_len;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_field(input int i, input logic [6:0] a, input logic [7:0] d);
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = d;
  endtask

  task automatic push_exp(input int i, input logic ack, input logic tmo, input bit stmo);
    exp_t e;
    e.g    = 4'(1) << i;
    e.a    = req_addr[7*i +: 7];
    e.d    = req_data[8*i +: 8];
    e.ack  = ack;
    e.tmo  = tmo;
    e.stmo = stmo;
    sb.push_back(e);
  endtask

  // Follows one grant from request to done; called right after req is driven.
  task automatic run_txn(input bit chk_lat, input int lat_exp, input bit drop_req);
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (grant == '0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("grant", grant, e.g);
    $display("txn: grant=%b addr=%h data=%h", grant, e.a, e.d);
    if (chk_lat) chk("grant_latency", n, lat_exp);
    if (drop_req) begin
      req      = '0;
      req_addr = ~req_addr;
      req_data = ~req_data;
    end
    @(negedge clk);
    chk("m_enable", m_enable, 1);
    chk("m_slave_addr", m_slave_addr, e.a);
    chk("m_data", m_data, e.d);
    @(negedge clk);
    chk("m_enable_pulse", m_enable, 0);
    n = 1;
    while (done == '0 && n < XFER_TIMEOUT + 50) begin
      @(negedge clk);
      n++;
    end
    chk("done", done, e.g);
    chk("ack_ok", ack_ok, e.ack);
    chk("timeout_err", timeout_err, e.tmo);
    if (e.stmo) chk("start_timeout_latency", n, START_TIMEOUT);
    $display("txn: done=%b ack_ok=%b timeout_err=%b", done, ack_ok, timeout_err);
    @(negedge clk);
    chk("done_clear", {done, ack_ok, timeout_err}, 0);
    chk("grant_clear", grant, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req          = '0;
    req_addr     = '0;
    req_data     = '0;
    mdl_stuck    = 1'b0;
    mdl_no_start = 1'b0;
    mdl_ack      = 1'b1;
    mdl_len      = 3;

    repeat (3) @(negedge clk);
    chk("reset_state", {grant, done, ack_ok, timeout_err, arb_busy, m_enable, m_slave_addr, m_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with all four requesting continuously.
    set_field(0, 7'h10, 8'h01);
    set_field(1, 7'h21, 8'h12);
    set_field(2, 7'h32, 8'h23);
    set_field(3, 7'h43, 8'h34);
    push_exp(0, 1'b1, 1'b0, 1'b0);
    push_exp(1, 1'b1, 1'b0, 1'b0);
    push_exp(2, 1'b1, 1'b0, 1'b0);
    push_exp(3, 1'b1, 1'b0, 1'b0);
    push_exp(0, 1'b1, 1'b0, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) run_txn(1'b1, 1, 1'b0);

    // Single request; fields and req change after the grant.
    req = '0;
    set_field(1, 7'h50, 8'hA5);
    push_exp(1, 1'b1, 1'b0, 1'b0);
    req = 4'b0010;
    run_txn(1'b1, 1, 1'b1);

    // NACK.
    mdl_ack = 1'b0;
    set_field(2, 7'h2C, 8'h3C);
    push_exp(2, 1'b0, 1'b0, 1'b0);
    req = 4'b0100;
    run_txn(1'b1, 1, 1'b0);
    req     = '0;
    mdl_ack = 1'b1;

    // Start timeout: master never goes busy.
    mdl_no_start = 1'b1;
    set_field(0, 7'h11, 8'h22);
    push_exp(0, 1'b0, 1'b1, 1'b1);
    req = 4'b0001;
    run_txn(1'b1, 1, 1'b0);
    req          = '0;
    mdl_no_start = 1'b0;

    // Pointer moved past requester 0, so requester 1 wins.
    set_field(1, 7'h12, 8'h34);
    push_exp(1, 1'b1, 1'b0, 1'b0);
    req = 4'b0011;
    run_txn(1'b1, 1, 1'b0);
    req = '0;

    // Stuck master: transfer timeout, then grants blocked while busy stays high.
    mdl_stuck = 1'b1;
    mdl_len   = 1;
    set_field(2, 7'h33, 8'h44);
    push_exp(2, 1'b0, 1'b1, 1'b0);
    req = 4'b0100;
    run_txn(1'b1, 1, 1'b0);
    set_field(0, 7'h55, 8'h66);
    push_exp(0, 1'b1, 1'b0, 1'b0);
    req  = 4'b0001;
    seen = '0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | grant;
    end
    chk("stuck_blocks_grant", seen, 0);
    mdl_stuck = 1'b0;
    mdl_len   = 3;
    run_txn(1'b1, 1, 1'b0);
    req = '0;

    // Reset during WAIT_DONE.
    mdl_stuck = 1'b1;
    mdl_len   = 1;
    set_field(2, 7'h3A, 8'h5B);
    req = 4'b0100;
    cyc = 0;
    while (grant == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_grant", grant, 4'b0100);
    repeat (6) @(negedge clk);
    chk("pre_reset_arb_busy", arb_busy, 1);
    rst_n = 1'b0;
    req   = 4'b1000;
    set_field(3, 7'h6E, 8'hC3);
    #1;
    chk("async_reset_outputs", {grant, done, ack_ok, timeout_err, arb_busy, m_enable, m_slave_addr, m_data}, 0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    mdl_stuck = 1'b0;
    mdl_len   = 3;
    push_exp(3, 1'b1, 1'b0, 1'b0);
    run_txn(1'b1, 1, 1'b0);
    req = '0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
